ex_flag_unit: RTL and testbench

Condition-code register (CCR) stage directly downstream of the 8-bit execute ALU.
- Consumes the ALU opcode, operands and result, and computes Z/N/C/V correctly with 9-bit internal arithmetic.
- Registers the flags and resolves the conditional-branch decision (JZ/JN/JC/JV/LOOP) for the fetch/decode flush logic.
- Keeps a small flag stack so interrupt entry and RTI can save and restore the CCR.

---
 rtl/ex_flag_unit_pkg.sv | 43 ++++
 rtl/ex_flag_unit_flag_stack.sv | 85 ++++++++
 rtl/ex_flag_unit.sv | 143 ++++++++++++++
 tb/tb_ex_flag_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ex_flag_unit_pkg.sv
// Shared definitions for the condition-code stage: opcodes, flag bit
// positions, the flag vector type and a small helper for Z/N updates.
package ex_flag_unit_pkg;

    localparam int OP_W_DEF = 5;

    // ALU opcodes that the flag stage reacts to
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_RLC  = 5'b00110;
    localparam logic [4:0] OP_RRC  = 5'b00111;
    localparam logic [4:0] OP_SETC = 5'b01000;
    localparam logic [4:0] OP_CLRC = 5'b01001;
    localparam logic [4:0] OP_NOT  = 5'b01110;
    localparam logic [4:0] OP_NEG  = 5'b01111;
    localparam logic [4:0] OP_INC  = 5'b10000;
    localparam logic [4:0] OP_DEC  = 5'b10001;
    localparam logic [4:0] OP_JZ   = 5'b10010;
    localparam logic [4:0] OP_JN   = 5'b10011;
    localparam logic [4:0] OP_JC   = 5'b10100;
    localparam logic [4:0] OP_JV   = 5'b10101;
    localparam logic [4:0] OP_LOOP = 5'b10110;

    // Bit positions inside the CCR {V,C,N,Z}
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    typedef logic [3:0] flag_t;

    // Return f with Z and N recomputed from an 8-bit result
    function automatic flag_t set_zn(input flag_t f, input logic [7:0] r);
        flag_t g;
        g        = f;
        g[FLG_Z] = (r == 8'h00);
        g[FLG_N] = r[7];
        return g;
    endfunction

endpackage

// File: rtl/ex_flag_unit_flag_stack.sv
// LIFO of saved CCR values for nested interrupts. A push while full and a
// pop while empty are dropped and latch sticky error bits until reset.
module flag_stack
    import ex_flag_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  flag_t push_data,
    output flag_t top_data,
    output logic  full,
    output logic  empty,
    output logic  ovf,
    output logic  unf
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    flag_t            slots_q [DEPTH];
    flag_t            slots_d [DEPTH];
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    assign full  = (ptr_q == PTR_W'(DEPTH));
    assign empty = (ptr_q == '0);
    assign ovf   = ovf_q;
    assign unf   = unf_q;

    // Top-of-stack read mux: slot ptr-1 when not empty, zero otherwise
    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr_q == PTR_W'(i + 1)) begin
                top_data = slots_q[i];
            end
        end
    end

    // Next pointer, slot contents and sticky errors; push takes priority
    always_comb begin
        ptr_d   = ptr_q;
        slots_d = slots_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ptr_q == PTR_W'(i)) begin
                        slots_d[i] = push_data;
                    end
                end
                ptr_d = ptr_q + PTR_ONE;
            end
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = ptr_q - PTR_ONE;
            end
        end
    end

    // Stack state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            slots_q <= '{default: '0};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            slots_q <= slots_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: rtl/ex_flag_unit.sv
// Condition-code register stage behind the 8-bit ALU. Computes Z/N/C/V
// from the EX opcode, operands and result, resolves conditional branches
// against the registered flags, and saves/restores the CCR on interrupt
// entry and return through a small flag stack.
module ex_flag_unit
    import ex_flag_unit_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2,
    parameter int OP_W         = OP_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            stall,
    input  logic [OP_W-1:0] alu_op,
    input  logic [7:0]      op_a,
    input  logic [7:0]      op_b,
    input  logic [7:0]      alu_result,
    input  logic            intr_save,
    input  logic            rti,
    output logic [3:0]      flags,
    output logic            branch_taken,
    output logic            stack_ovf,
    output logic            stack_unf
);

    flag_t flags_q, flags_d;
    flag_t flags_upd;
    flag_t stk_top;
    logic  upd;
    logic  stk_push, stk_pop;
    logic  stk_full, stk_empty;

    assign upd      = ex_valid & ~stall;
    // intr_save wins over a same-cycle rti; a stall freezes the stack
    assign stk_push = intr_save & ~stall;
    assign stk_pop  = rti & ~stall & ~intr_save;

    // Flag effect of the EX instruction plus branch resolution
    always_comb begin
        flags_upd    = flags_q;
        branch_taken = 1'b0;
        if (upd) begin
            case (alu_op)
                OP_ADD: begin
                    flags_upd        = set_zn(flags_q, alu_result);
                    flags_upd[FLG_C] = ({1'b0, op_a} + {1'b0, op_b}) > 9'd255;
                    flags_upd[FLG_V] = (op_a[7] == op_b[7]) && (alu_result[7] != op_a[7]);
                end
                OP_SUB: begin
                    // 9-bit difference wraps above 255 exactly when A < B
                    flags_upd        = set_zn(flags_q, alu_result);
                    flags_upd[FLG_C] = ({1'b0, op_a} - {1'b0, op_b}) > 9'd255;
                    flags_upd[FLG_V] = (op_a[7] != op_b[7]) && (alu_result[7] != op_a[7]);
                end
                OP_AND, OP_OR, OP_NOT: begin
                    flags_upd = set_zn(flags_q, alu_result);
                end
                OP_RLC: begin
                    flags_upd        = set_zn(flags_q, alu_result);
                    flags_upd[FLG_C] = op_b[7];
                end
                OP_RRC: begin
                    flags_upd        = set_zn(flags_q, alu_result);
                    flags_upd[FLG_C] = op_b[0];
                end
                OP_NEG: begin
                    flags_upd        = set_zn(flags_q, alu_result);
                    flags_upd[FLG_C] = (op_b != 8'h00);
                    flags_upd[FLG_V] = (op_b == 8'h80);
                end
                OP_INC: begin
                    flags_upd        = set_zn(flags_q, alu_result);
                    flags_upd[FLG_C] = (op_b == 8'hFF);
                    flags_upd[FLG_V] = (op_b == 8'h7F);
                end
                OP_DEC: begin
                    flags_upd        = set_zn(flags_q, alu_result);
                    flags_upd[FLG_C] = (op_b == 8'h00);
                    flags_upd[FLG_V] = (op_b == 8'h80);
                end
                OP_SETC: flags_upd[FLG_C] = 1'b1;
                OP_CLRC: flags_upd[FLG_C] = 1'b0;
                // A taken flag branch consumes the flag it tested
                OP_JZ: if (flags_q[FLG_Z]) begin
                    branch_taken     = 1'b1;
                    flags_upd[FLG_Z] = 1'b0;
                end
                OP_JN: if (flags_q[FLG_N]) begin
                    branch_taken     = 1'b1;
                    flags_upd[FLG_N] = 1'b0;
                end
                OP_JC: if (flags_q[FLG_C]) begin
                    branch_taken     = 1'b1;
                    flags_upd[FLG_C] = 1'b0;
                end
                OP_JV: if (flags_q[FLG_V]) begin
                    branch_taken     = 1'b1;
                    flags_upd[FLG_V] = 1'b0;
                end
                // Decrement-and-test with 8-bit wrap, so A=0 loops
                OP_LOOP: branch_taken = ((op_a - 8'd1) != 8'd0);
                default: flags_upd = flags_q;
            endcase
        end
    end

    // A successful restore overrides whatever the EX instruction did
    always_comb begin
        flags_d = flags_upd;
        if (stk_pop && !stk_empty) begin
            flags_d = stk_top;
        end
    end

    // CCR register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // The saved value is the CCR as it will be next cycle
    flag_stack #(
        .DEPTH (SHADOW_DEPTH)
    ) u_flag_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (flags_upd),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .ovf       (stack_ovf),
        .unf       (stack_unf)
    );

    assign flags = flags_q;

endmodule

// File: tb/tb_ex_flag_unit.sv
// Directed bench for ex_flag_unit: hand-computed flag, branch and
// sticky-error expectations, with a queue modelling the saved CCR values.
module tb_ex_flag_unit;
    import ex_flag_unit_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       ex_valid;
    logic       stall;
    logic [4:0] alu_op;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] alu_result;
    logic       intr_save;
    logic       rti;
    logic [3:0] flags;
    logic       branch_taken;
    logic       stack_ovf;
    logic       stack_unf;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] exp_q[$];

    ex_flag_unit #(
        .SHADOW_DEPTH (2),
        .OP_W         (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .stall        (stall),
        .alu_op       (alu_op),
        .op_a         (op_a),
        .op_b         (op_b),
        .alu_result   (alu_result),
        .intr_save    (intr_save),
        .rti          (rti),
        .flags        (flags),
        .branch_taken (branch_taken),
        .stack_ovf    (stack_ovf),
        .stack_unf    (stack_unf)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one vector at a negedge, check branch before the edge and
    // the registered flags after it
    task automatic vec(input string tag, input logic [4:0] op,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                       input logic v, input logic s, input logic sv, input logic rt,
                       input logic exp_bt, input logic [3:0] exp_f);
        alu_op     = op;
        op_a       = a;
        op_b       = b;
        alu_result = r;
        ex_valid   = v;
        stall      = s;
        intr_save  = sv;
        rti        = rt;
        #1;
        check({tag, ".bt"}, {7'd0, branch_taken}, {7'd0, exp_bt});
        @(posedge clk);
        @(negedge clk);
        ex_valid  = 1'b0;
        stall     = 1'b0;
        intr_save = 1'b0;
        rti       = 1'b0;
        check({tag, ".flags"}, {4'd0, flags}, {4'd0, exp_f});
    endtask

    task automatic check_sticky(input string tag, input logic ovf, input logic unf);
        check({tag, ".ovf"}, {7'd0, stack_ovf}, {7'd0, ovf});
        check({tag, ".unf"}, {7'd0, stack_unf}, {7'd0, unf});
    endtask

    initial begin
        rst_n      = 1'b0;
        ex_valid   = 1'b0;
        stall      = 1'b0;
        alu_op     = '0;
        op_a       = '0;
        op_b       = '0;
        alu_result = '0;
        intr_save  = 1'b0;
        rti        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst.flags", {4'd0, flags}, 8'h00);
        check("rst.bt", {7'd0, branch_taken}, 8'h00);
        check_sticky("rst", 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Flag stack: pushes capture the same-cycle update
        exp_q.push_back(4'hE);
        vec("push1", OP_NEG, 8'h00, 8'h80, 8'h80, 1, 0, 1, 0, 0, 4'hE);
        exp_q.push_back(4'h1);
        vec("push2", OP_SUB, 8'h05, 8'h05, 8'h00, 1, 0, 1, 0, 0, 4'h1);
        vec("push3_full", OP_INC, 8'h00, 8'hFF, 8'h00, 1, 0, 1, 0, 0, 4'h5);
        check_sticky("push3_full", 1'b1, 1'b0);
        vec("rti1", 5'b00000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, exp_q.pop_back());
        vec("rti2_over_upd", OP_ADD, 8'h7F, 8'h01, 8'h80, 1, 0, 0, 1, 0, exp_q.pop_back());
        vec("rti3_empty", 5'b00000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 4'hE);
        check_sticky("rti3_empty", 1'b1, 1'b1);
        vec("rti4_empty_upd", OP_AND, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 0, 4'hD);

        // Asynchronous reset in the middle of a cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.flags", {4'd0, flags}, 8'h00);
        check_sticky("arst", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic flags
        vec("add_ovf", OP_ADD, 8'h7F, 8'h01, 8'h80, 1, 0, 0, 0, 0, 4'hA);
        vec("add_carry", OP_ADD, 8'hFF, 8'h01, 8'h00, 1, 0, 0, 0, 0, 4'h5);
        vec("sub_eq", OP_SUB, 8'h05, 8'h05, 8'h00, 1, 0, 0, 0, 0, 4'h1);
        vec("jz_taken", OP_JZ, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 1, 4'h0);
        vec("jz_not", OP_JZ, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 4'h0);
        vec("sub_borrow", OP_SUB, 8'h01, 8'h02, 8'hFF, 1, 0, 0, 0, 0, 4'h6);
        vec("jc_taken", OP_JC, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 1, 4'h2);
        vec("jn_taken", OP_JN, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 1, 4'h0);
        vec("jv_not", OP_JV, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 4'h0);
        vec("inc_ff", OP_INC, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 0, 0, 4'h5);
        vec("and_nz", OP_AND, 8'h00, 8'h00, 8'h01, 1, 0, 0, 0, 0, 4'h4);
        vec("or_neg", OP_OR, 8'h00, 8'h00, 8'h80, 1, 0, 0, 0, 0, 4'h6);
        vec("not_zero", OP_NOT, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 4'h5);
        vec("clrc", OP_CLRC, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 4'h1);
        vec("setc", OP_SETC, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 4'h5);
        vec("neg_80", OP_NEG, 8'h00, 8'h80, 8'h80, 1, 0, 0, 0, 0, 4'hE);
        vec("jv_taken", OP_JV, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 1, 4'h6);
        vec("dec_80", OP_DEC, 8'h00, 8'h80, 8'h7F, 1, 0, 0, 0, 0, 4'h8);
        vec("inc_7f", OP_INC, 8'h00, 8'h7F, 8'h80, 1, 0, 0, 0, 0, 4'hA);
        vec("rlc", OP_RLC, 8'h00, 8'h80, 8'h00, 1, 0, 0, 0, 0, 4'hD);
        vec("rrc", OP_RRC, 8'h00, 8'h02, 8'h81, 1, 0, 0, 0, 0, 4'hA);
        vec("undef_op", 5'b11111, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 4'hA);
        vec("not_valid", OP_ADD, 8'h05, 8'h05, 8'h00, 0, 0, 0, 0, 0, 4'hA);
        vec("neg_zero", OP_NEG, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 4'h1);

        // LOOP and stall
        vec("loop_1", OP_LOOP, 8'h01, 8'h00, 8'h00, 1, 0, 0, 0, 0, 4'h1);
        vec("loop_0", OP_LOOP, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 1, 4'h1);
        vec("loop_5", OP_LOOP, 8'h05, 8'h00, 8'h00, 1, 0, 0, 0, 1, 4'h1);
        vec("loop_stall", OP_LOOP, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 0, 4'h1);
        vec("jz_stall_save", OP_JZ, 8'h00, 8'h00, 8'h00, 1, 1, 1, 0, 0, 4'h1);
        vec("add_stall_rti", OP_ADD, 8'h7F, 8'h01, 8'h80, 1, 1, 0, 1, 0, 4'h1);
        check_sticky("stall", 1'b0, 1'b0);

        // intr_save beats rti in the same cycle
        exp_q.push_back(4'hA);
        vec("save_and_rti", OP_ADD, 8'h7F, 8'h01, 8'h80, 1, 0, 1, 1, 0, 4'hA);
        check_sticky("save_and_rti", 1'b0, 1'b0);
        vec("add_carry2", OP_ADD, 8'hFF, 8'h01, 8'h00, 1, 0, 0, 0, 0, 4'h5);
        vec("rti_restore", 5'b00000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, exp_q.pop_back());
        check_sticky("rti_restore", 1'b0, 1'b0);
        vec("rti_empty2", 5'b00000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 4'hA);
        check_sticky("rti_empty2", 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
